way_fill_demux_8: RTL

//  Write-side counterpart of the decoded way mux: takes one entry plus a one-hot way select and

---
 rtl/way_fill_demux_8_pkg.sv | 22 ++
 rtl/way_fill_demux_8_find_first_one_index.sv | 25 ++
 rtl/way_fill_demux_8.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/way_fill_demux_8_pkg.sv
// Shared definitions for the way fill demux: FSM encodings and index-width helper.
package way_fill_demux_8_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int DEFAULT_NUMBER_WAY = 8;
  localparam int DEFAULT_ENTRY_W    = 32;

  // Width needed to hold a way index 0..n-1; never below 1 bit.
  function automatic int way_idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int DEFAULT_WAY_IDX_W = way_idx_w(DEFAULT_NUMBER_WAY);

endpackage

// File: rtl/way_fill_demux_8_find_first_one_index.sv
// Lowest-set-bit finder: reports whether any bit is set and the index of the lowest one.
module find_first_one_index
  import way_fill_demux_8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_NUMBER_WAY,
  parameter int IDX_W = way_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_in,
  output logic             found_out,
  output logic [IDX_W-1:0] index_out
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    found_out = 1'b0;
    index_out = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_in[i]) begin
        found_out = 1'b1;
        index_out = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/way_fill_demux_8.sv
// Way fill demux: scatters one entry into one of NUMBER_WAY registered way slots,
// tracks per-way valid bits, allocates a victim when no way is selected, and
// supports per-way invalidate plus a one-way-per-cycle flush.
//
// Handshake: a write is accepted on a rising edge where write_valid_in and
// write_ready_out are both high; ready does not depend on valid, and the data
// becomes visible (with write_done_out) one edge after acceptance.
module way_fill_demux_8
  import way_fill_demux_8_pkg::*;
#(
  parameter int NUMBER_WAY                = DEFAULT_NUMBER_WAY,
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = DEFAULT_ENTRY_W
) (
  input  logic                                            clk_in,
  input  logic                                            reset_in,
  input  logic                                            write_valid_in,
  output logic                                            write_ready_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]            write_data_in,
  input  logic [NUMBER_WAY-1:0]                           write_sel_in,
  input  logic [NUMBER_WAY-1:0]                           invalidate_in,
  input  logic                                            flush_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS*NUMBER_WAY-1:0] way_flatted_out,
  output logic [NUMBER_WAY-1:0]                           way_valid_out,
  output logic [NUMBER_WAY-1:0]                           write_way_out,
  output logic                                            write_done_out,
  output logic                                            flush_busy_out
);

  localparam int W     = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int N     = NUMBER_WAY;
  localparam int IDX_W = way_idx_w(N);
  localparam logic [IDX_W-1:0] LAST_WAY = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] flush_idx_q, flush_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]     valid_q, valid_d;
  logic [N-1:0]     write_way_q, write_way_d;
  logic             write_done_q, write_done_d;
  logic [W-1:0]     data_q [N];
  logic [W-1:0]     data_d [N];

  logic             sel_found, inv_found;
  logic [IDX_W-1:0] sel_idx, inv_idx, target_idx;
  logic             use_rr, accept;
  logic [N-1:0]     target_onehot;

  find_first_one_index #(.WIDTH(N), .IDX_W(IDX_W)) u_sel_ffo (
    .vec_in    (write_sel_in),
    .found_out (sel_found),
    .index_out (sel_idx)
  );

  find_first_one_index #(.WIDTH(N), .IDX_W(IDX_W)) u_free_ffo (
    .vec_in    (~valid_q),
    .found_out (inv_found),
    .index_out (inv_idx)
  );

  assign write_ready_out = (state_q == IDLE) && !flush_in;
  assign accept          = write_valid_in && write_ready_out;

  // Target way: explicit select, else first invalid way, else round-robin victim.
  always_comb begin
    use_rr        = !sel_found && !inv_found;
    target_idx    = sel_found ? sel_idx : (inv_found ? inv_idx : rr_ptr_q);
    target_onehot = '0;
    target_onehot[target_idx] = 1'b1;
  end

  // Next-state: FSM, flush walk, valid bits (write beats invalidate), data, rr pointer.
  always_comb begin
    state_d      = state_q;
    flush_idx_d  = flush_idx_q;
    rr_ptr_d     = rr_ptr_q;
    valid_d      = valid_q & ~invalidate_in;
    write_way_d  = write_way_q;
    write_done_d = accept;
    data_d       = data_q;

    case (state_q)
      IDLE: begin
        if (flush_in) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end
      end
      FLUSH: begin
        valid_d[flush_idx_q] = 1'b0;
        if (flush_idx_q == LAST_WAY) begin
          state_d     = IDLE;
          flush_idx_d = '0;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      valid_d[target_idx] = 1'b1;
      data_d[target_idx]  = write_data_in;
      write_way_d         = target_onehot;
      if (use_rr) begin
        rr_ptr_d = (rr_ptr_q == LAST_WAY) ? '0 : rr_ptr_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous reset; a write in flight at reset is dropped.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      flush_idx_q  <= '0;
      rr_ptr_q     <= '0;
      valid_q      <= '0;
      write_way_q  <= '0;
      write_done_q <= 1'b0;
      for (int i = 0; i < N; i++) data_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      flush_idx_q  <= flush_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      valid_q      <= valid_d;
      write_way_q  <= write_way_d;
      write_done_q <= write_done_d;
      for (int i = 0; i < N; i++) data_q[i] <= data_d[i];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign way_flatted_out[g*W +: W] = data_q[g];
  end

  assign way_valid_out  = valid_q;
  assign write_way_out  = write_way_q;
  assign write_done_out = write_done_q;
  assign flush_busy_out = (state_q == FLUSH);

endmodule
